lfsr_22_checker: RTL and testbench

Receive-side PRBS checker for the 22-bit maximal-length XNOR pattern used for simulated binary payloads (recurrence b[k] = b[k-22] XNOR b[k-21]). It takes one recovered bit per enabled cycle, self-synchronises a local reference register to the stream, then free-runs the reference and counts bit errors. It sits after the demodulator/slicer in the receive path and closes the loop on the transmit-side pattern source for BER measurement.

---
 rtl/lfsr_22_checker_pkg.sv | 22 ++
 rtl/lfsr_22_checker_if.sv | 22 ++
 rtl/lfsr_22_loss_mon.sv | 34 +++
 rtl/lfsr_22_checker.sv | 126 ++++++++++++
 tb/tb_lfsr_22_checker.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_22_checker_pkg.sv
// Shared constants for the 22-bit XNOR PRBS pattern (b[k] = b[k-22] XNOR b[k-21]).
// The transmit-side generator uses the same length, taps and state encoding.
package lfsr_22_checker_pkg;

    localparam int LFSR_LEN = 22;
    localparam int TAP_HI   = 21;
    localparam int TAP_LO   = 20;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    typedef logic [LFSR_LEN-1:0] lfsr_t;

    // r[0] is the newest bit and r[21] the oldest, so the taps hold b[k-22] and b[k-21].
    function automatic logic lfsr_pred(input lfsr_t r);
        return ~(r[TAP_HI] ^ r[TAP_LO]);
    endfunction

endpackage

// File: rtl/lfsr_22_checker_if.sv
// Bit-stream and status bundle between the slicer/BER logic and the PRBS checker.
interface lfsr_22_checker_if #(
    parameter int CNT_W = 32
);
    logic             clk_en;
    logic             rx_bit;
    logic             clear_counts;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output clk_en, rx_bit, clear_counts,
        input  locked, err_pulse, bit_count, err_count
    );

    modport slave (
        input  clk_en, rx_bit, clear_counts,
        output locked, err_pulse, bit_count, err_count
    );
endinterface

// File: rtl/lfsr_22_loss_mon.sv
// Loss-of-lock monitor: counts checked bits and errors over a fixed window and
// strobes loss on the bit that brings the window error count up to the threshold.
module lfsr_22_loss_mon #(
    parameter int WIN_LEN     = 256,
    parameter int LOSS_THRESH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_err,
    output logic loss
);
    localparam int WB_W = $clog2(WIN_LEN + 1);
    localparam int WE_W = $clog2(LOSS_THRESH + 1);

    logic [WB_W-1:0] win_bits;
    logic [WE_W-1:0] win_errs;
    logic            win_full;

    assign loss     = bit_valid && bit_err && (win_errs == WE_W'(LOSS_THRESH - 1));
    assign win_full = bit_valid && (win_bits == WB_W'(WIN_LEN - 1));

    // Loss takes precedence over a window rollover on the same bit; both clear.
    always_ff @(posedge clk) begin
        if (reset || clear || loss || win_full) begin
            win_bits <= '0;
            win_errs <= '0;
        end else if (bit_valid) begin
            win_bits <= win_bits + WB_W'(1);
            win_errs <= win_errs + WE_W'(bit_err);
        end
    end
endmodule

// File: rtl/lfsr_22_checker.sv
// Receive-side PRBS-22 checker: self-synchronises a reference register to the
// incoming stream, then free-runs it and counts bit errors for BER measurement.
module lfsr_22_checker
    import lfsr_22_checker_pkg::*;
#(
    parameter int VERIFY_LEN  = 64,
    parameter int WIN_LEN     = 256,
    parameter int LOSS_THRESH = 32,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    lfsr_22_checker_if.slave    bus
);
    localparam int FILL_W = $clog2(LFSR_LEN);
    localparam int RUN_W  = $clog2(VERIFY_LEN + 1);

    chk_state_t       state, state_next;
    lfsr_t            r, r_next;
    logic [FILL_W-1:0] fill, fill_next;
    logic [RUN_W-1:0]  run, run_next;
    logic             pred, bit_err, count_bit, enter_lock, loss;
    logic             err_pulse_r;
    logic [CNT_W-1:0] bit_count_r, err_count_r;

    assign pred      = lfsr_pred(r);
    assign bit_err   = bus.rx_bit != pred;
    assign count_bit = bus.clk_en && (state == LOCKED);

    lfsr_22_loss_mon #(
        .WIN_LEN     (WIN_LEN),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_loss_mon (
        .clk       (clk),
        .reset     (reset),
        .clear     (enter_lock),
        .bit_valid (count_bit),
        .bit_err   (bit_err),
        .loss      (loss)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        r_next     = r;
        fill_next  = fill;
        run_next   = run;
        enter_lock = 1'b0;
        if (bus.clk_en) begin
            case (state)
                LOAD: begin
                    r_next = {r[LFSR_LEN-2:0], bus.rx_bit};
                    if (fill == FILL_W'(LFSR_LEN - 1)) begin
                        fill_next  = '0;
                        run_next   = '0;
                        state_next = VERIFY;
                    end else begin
                        fill_next = fill + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    r_next = {r[LFSR_LEN-2:0], bus.rx_bit};
                    // All-ones is the XNOR lockup state: it self-predicts a stuck-high line.
                    if (bit_err || (r == '1)) begin
                        state_next = LOAD;
                        fill_next  = '0;
                        run_next   = '0;
                    end else if (run == RUN_W'(VERIFY_LEN - 1)) begin
                        state_next = LOCKED;
                        run_next   = '0;
                        enter_lock = 1'b1;
                    end else begin
                        run_next = run + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a line error never enters r.
                    r_next = {r[LFSR_LEN-2:0], pred};
                    if (loss) begin
                        state_next = LOAD;
                        fill_next  = '0;
                        run_next   = '0;
                    end
                end
                default: state_next = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r           <= '0;
            fill        <= '0;
            run         <= '0;
            err_pulse_r <= 1'b0;
            bit_count_r <= '0;
            err_count_r <= '0;
        end else begin
            r           <= r_next;
            fill        <= fill_next;
            run         <= run_next;
            err_pulse_r <= count_bit && bit_err;
            // The whole block is frozen between strobes, counter clear included.
            if (bus.clk_en && bus.clear_counts) begin
                bit_count_r <= '0;
                err_count_r <= '0;
            end else if (count_bit) begin
                if (bit_count_r != '1)            bit_count_r <= bit_count_r + CNT_W'(1);
                if (bit_err && err_count_r != '1) err_count_r <= err_count_r + CNT_W'(1);
            end
        end
    end

    assign bus.locked    = (state == LOCKED);
    assign bus.err_pulse = err_pulse_r;
    assign bus.bit_count = bit_count_r;
    assign bus.err_count = err_count_r;
endmodule

// File: tb/tb_lfsr_22_checker.sv
// Self-checking bench for lfsr_22_checker: scenario table with end-of-run
// expectations, a per-cycle behavioural model, and hand-written corner sequences.
module tb_lfsr_22_checker;
    localparam int CNT_W   = 32;
    localparam int GEN_N   = 1000;
    localparam int M_PRBS  = 0;
    localparam int M_ONES  = 1;
    localparam int M_NOISY = 2;
    localparam logic [21:0] SEED = {1'b1, 21'b111010110111101010111};
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    lfsr_22_checker_if #(.CNT_W(CNT_W)) bus ();

    lfsr_22_checker #(
        .VERIFY_LEN  (64),
        .WIN_LEN     (256),
        .LOSS_THRESH (32),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    n_bits;
        int    en_period;
        int    mode;
        int    flip_start;
        int    flip_stride;
        int    flip_count;
        bit    exp_locked;
        int    exp_bits;
        int    exp_errs;
    } vec_t;

    int  n_vec  = 0;
    int  n_miss = 0;
    int  pulses = 0;
    bit  gen [GEN_N];

    // Behavioural model: history of the reference stream, oldest first.
    bit     hist [$];
    int     run, wbits, werrs;
    bit     m_lock, m_pulse;
    longint m_bits, m_errs;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        run = 0; wbits = 0; werrs = 0;
        m_lock = 0; m_pulse = 0; m_bits = 0; m_errs = 0;
    endtask

    task automatic model_step(input bit rx, input bit clr);
        bit p, e;
        int ones;
        m_pulse = 0;
        if (m_lock) begin
            p = !(hist[0] ^ hist[1]);
            e = (rx != p);
            hist.push_back(p);
            void'(hist.pop_front());
            m_pulse = e;
            if (m_bits < CNT_MAX) m_bits++;
            if (e && m_errs < CNT_MAX) m_errs++;
            wbits++;
            werrs += int'(e);
            if (werrs == 32) begin
                m_lock = 0; hist.delete(); run = 0; wbits = 0; werrs = 0;
            end else if (wbits == 256) begin
                wbits = 0; werrs = 0;
            end
        end else if (hist.size() < 22) begin
            hist.push_back(rx);
        end else begin
            p = !(hist[0] ^ hist[1]);
            ones = 0;
            foreach (hist[i]) ones += int'(hist[i]);
            if (rx != p || ones == 22) begin
                hist.delete();
                run = 0;
            end else begin
                hist.push_back(rx);
                void'(hist.pop_front());
                run++;
                if (run == 64) begin
                    m_lock = 1; run = 0; wbits = 0; werrs = 0;
                end
            end
        end
        if (clr) begin
            m_bits = 0;
            m_errs = 0;
        end
    endtask

    function automatic logic [65:0] dut_vec();
        return {bus.locked, bus.err_pulse, bus.bit_count, bus.err_count};
    endfunction

    function automatic logic [65:0] model_vec();
        return {m_lock, m_pulse, m_bits[31:0], m_errs[31:0]};
    endfunction

    task automatic apply(input bit en, input bit rx, input bit clr);
        bus.clk_en       = en;
        bus.rx_bit       = rx;
        bus.clear_counts = clr;
        @(posedge clk);
        #1;
        if (en) model_step(rx, clr);
        else    m_pulse = 0;
        if (bus.err_pulse) pulses++;
        check("cycle_vs_model", dut_vec(), model_vec());
    endtask

    task automatic reset_dut();
        reset            = 1'b1;
        bus.clk_en       = 1'b0;
        bus.rx_bit       = 1'b0;
        bus.clear_counts = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        pulses = 0;
        check("reset_state", dut_vec(), 66'd0);
    endtask

    function automatic bit stim_bit(input vec_t t, input int k);
        bit b;
        int d;
        case (t.mode)
            M_ONES:  b = 1'b1;
            M_NOISY: b = gen[k-1] ^ ($urandom_range(0, 99) < 30);
            default: begin
                b = gen[k-1];
                d = k - t.flip_start;
                if (t.flip_count > 0 && d >= 0 && (d % t.flip_stride) == 0 &&
                    (d / t.flip_stride) < t.flip_count)
                    b = ~b;
            end
        endcase
        return b;
    endfunction

    vec_t tbl [6];

    initial begin
        bus.clk_en       = 1'b0;
        bus.rx_bit       = 1'b0;
        bus.clear_counts = 1'b0;

        for (int i = 0; i < GEN_N; i++) begin
            if (i < 22) gen[i] = SEED[21-i];
            else        gen[i] = !(gen[i-22] ^ gen[i-21]);
        end

        tbl[0] = '{"clean_1000", 1000, 1, M_PRBS,    0, 1,  0, 1'b1, 914,  0};
        tbl[1] = '{"flip_500",   1000, 1, M_PRBS,  500, 1,  1, 1'b1, 914,  1};
        tbl[2] = '{"burst_32",   1000, 1, M_PRBS,  350, 5, 32, 1'b1, 828, 32};
        tbl[3] = '{"const_one",   500, 1, M_ONES,    0, 1,  0, 1'b0,   0,  0};
        tbl[4] = '{"noisy_30",    500, 1, M_NOISY,   0, 1,  0, 1'b0,   0,  0};
        tbl[5] = '{"en_1in4",     400, 4, M_PRBS,    0, 1,  0, 1'b1, 314,  0};

        for (int v = 0; v < 6; v++) begin
            int k;
            reset_dut();
            k = 0;
            while (k < tbl[v].n_bits) begin
                for (int ph = 0; ph < tbl[v].en_period; ph++) begin
                    if (ph == 0) begin
                        k++;
                        apply(1'b1, stim_bit(tbl[v], k), 1'b0);
                    end else begin
                        apply(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                    end
                end
            end
            check({tbl[v].name, "_locked"},    66'(bus.locked),    66'(tbl[v].exp_locked));
            check({tbl[v].name, "_bit_count"}, 66'(bus.bit_count), 66'(tbl[v].exp_bits));
            check({tbl[v].name, "_err_count"}, 66'(bus.err_count), 66'(tbl[v].exp_errs));
            check({tbl[v].name, "_pulses"},    66'(pulses),        66'(tbl[v].exp_errs));
        end

        // Lock latency: locked rises after the 86th bit, counting starts at bit 87.
        reset_dut();
        for (int k = 1; k <= 85; k++) apply(1'b1, gen[k-1], 1'b0);
        check("not_locked_at_85", 66'(bus.locked), 66'd0);
        apply(1'b1, gen[85], 1'b0);
        check("locked_at_86", 66'(bus.locked), 66'd1);
        check("bits_at_86", 66'(bus.bit_count), 66'd0);
        apply(1'b1, gen[86], 1'b0);
        check("bits_at_87", 66'(bus.bit_count), 66'd1);

        // One error, then clear_counts on the same bit as a second error.
        for (int k = 88; k <= 100; k++) apply(1'b1, gen[k-1], 1'b0);
        apply(1'b1, ~gen[100], 1'b0);
        check("first_err_pulse", 66'(bus.err_pulse), 66'd1);
        check("first_err_count", 66'(bus.err_count), 66'd1);
        for (int k = 102; k <= 109; k++) apply(1'b1, gen[k-1], 1'b0);
        apply(1'b1, ~gen[109], 1'b1);
        check("clear_bit_count", 66'(bus.bit_count), 66'd0);
        check("clear_err_count", 66'(bus.err_count), 66'd0);
        check("clear_keeps_lock", 66'(bus.locked), 66'd1);
        apply(1'b1, gen[110], 1'b0);
        check("count_after_clear", 66'(bus.bit_count), 66'd1);

        // Reset while locked overrides clk_en: all outputs zero the next cycle.
        reset            = 1'b1;
        bus.clk_en       = 1'b1;
        bus.rx_bit       = ~gen[111];
        bus.clear_counts = 1'b0;
        @(posedge clk);
        #1;
        check("reset_while_locked", dut_vec(), 66'd0);
        reset      = 1'b0;
        bus.clk_en = 1'b0;
        model_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
